ahb_master_resp_mux: RTL and testbench

// Per-master data-phase response path of the multilayer interconnect. Sits directly downstream of the

---
 rtl/ahb_master_resp_mux.sv | 123 ++++++++++++
 tb/tb_ahb_master_resp_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_resp_mux.sv
// Per-master AHB data-phase response path: registers the decoder select at each address-phase
// handshake, muxes the selected slave's response back, and hosts the default (ERROR) slave.
module ahb_master_resp_mux #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             i_hclk,
    input  logic                             i_hresetn,
    input  logic [NUM_SLAVES-1:0]            i_hsel,
    input  logic [1:0]                       i_htrans,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_hrdata_s,
    input  logic [NUM_SLAVES-1:0]            i_hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            i_hresp_s,
    output logic [DATA_WIDTH-1:0]            o_hrdata,
    output logic                             o_hready,
    output logic                             o_hresp
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    ds_state_t                 r_ds_state;
    ds_state_t                 w_ds_state_nxt;
    logic [NUM_SLAVES-1:0]     r_dp_sel;
    logic [NUM_SLAVES-1:0]     w_hsel_pri;
    logic                      w_unmapped_active;
    logic [DATA_WIDTH-1:0]     w_rdata_or;
    logic                      w_rdy_or;
    logic                      w_resp_or;

    // Keep only the lowest-index select; x & -x isolates the lowest set bit.
    function automatic logic [NUM_SLAVES-1:0] prio_lowest(input logic [NUM_SLAVES-1:0] sel);
        prio_lowest = sel & (~sel + {{(NUM_SLAVES-1){1'b0}}, 1'b1});
    endfunction

    assign w_hsel_pri        = prio_lowest(i_hsel);
    assign w_unmapped_active = (i_hsel == {NUM_SLAVES{1'b0}}) && i_htrans[1];

    // Data-phase select register, loaded on every address-phase handshake
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_dp_sel <= {NUM_SLAVES{1'b0}};
        end else if (o_hready) begin
            r_dp_sel <= w_hsel_pri;
        end
    end

    // Default-slave state register
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_ds_state <= DS_IDLE;
        end else begin
            r_ds_state <= w_ds_state_nxt;
        end
    end

    // Default-slave next state; a capture only occurs while o_hready is high
    always_comb begin
        w_ds_state_nxt = DS_IDLE;
        case (r_ds_state)
            DS_IDLE: begin
                if (o_hready && w_unmapped_active) begin
                    w_ds_state_nxt = DS_ERR1;
                end else begin
                    w_ds_state_nxt = DS_IDLE;
                end
            end
            DS_ERR1: w_ds_state_nxt = DS_ERR2;
            DS_ERR2: begin
                if (w_unmapped_active) begin
                    w_ds_state_nxt = DS_ERR1;
                end else begin
                    w_ds_state_nxt = DS_IDLE;
                end
            end
            default: w_ds_state_nxt = DS_IDLE;
        endcase
    end

    // AND-OR mux of slave responses; r_dp_sel is one-hot or zero
    always_comb begin
        w_rdata_or = {DATA_WIDTH{1'b0}};
        w_rdy_or   = 1'b0;
        w_resp_or  = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_rdata_or = w_rdata_or | (i_hrdata_s[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_dp_sel[k]}});
            w_rdy_or   = w_rdy_or  | (i_hreadyout_s[k] & r_dp_sel[k]);
            w_resp_or  = w_resp_or | (i_hresp_s[k] & r_dp_sel[k]);
        end
    end

    // Response to master: default-slave ERROR, selected slave, or zero-wait OKAY
    always_comb begin
        o_hready = 1'b1;
        o_hresp  = 1'b0;
        o_hrdata = {DATA_WIDTH{1'b0}};
        case (r_ds_state)
            DS_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = 1'b1;
            end
            DS_ERR2: begin
                o_hready = 1'b1;
                o_hresp  = 1'b1;
            end
            default: begin
                if (r_dp_sel != {NUM_SLAVES{1'b0}}) begin
                    o_hready = w_rdy_or;
                    o_hresp  = w_resp_or;
                    o_hrdata = w_rdata_or;
                end else begin
                    o_hready = 1'b1;
                    o_hresp  = 1'b0;
                    o_hrdata = {DATA_WIDTH{1'b0}};
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_master_resp_mux.sv
// Self-checking bench for ahb_master_resp_mux: directed scenarios plus random traffic
// compared against a data-phase-level reference model.
module tb_ahb_master_resp_mux;

    logic        i_hclk;
    logic        i_hresetn;
    logic [1:0]  i_hsel;
    logic [1:0]  i_htrans;
    logic [63:0] i_hrdata_s;
    logic [1:0]  i_hreadyout_s;
    logic [1:0]  i_hresp_s;
    logic [31:0] o_hrdata;
    logic        o_hready;
    logic        o_hresp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the current data phase is.
    // 0 = no transfer (OKAY), 1 = slave m_idx, 2 = ERROR beat 1, 3 = ERROR beat 2
    int m_kind = 0;
    int m_idx  = 0;

    ahb_master_resp_mux #(.NUM_SLAVES(2), .DATA_WIDTH(32)) dut (
        .i_hclk        (i_hclk),
        .i_hresetn     (i_hresetn),
        .i_hsel        (i_hsel),
        .i_htrans      (i_htrans),
        .i_hrdata_s    (i_hrdata_s),
        .i_hreadyout_s (i_hreadyout_s),
        .i_hresp_s     (i_hresp_s),
        .o_hrdata      (o_hrdata),
        .o_hready      (o_hready),
        .o_hresp       (o_hresp)
    );

    initial i_hclk = 1'b0;
    always #5 i_hclk = ~i_hclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, compare against the model mid-cycle, then advance the model.
    task automatic cyc(input logic [1:0] hsel, input logic [1:0] htrans,
                       input logic [1:0] rdy, input logic [1:0] resp,
                       input logic [31:0] d0, input logic [31:0] d1,
                       output logic obs_rdy, output logic obs_resp, output logic [31:0] obs_data);
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        i_hsel        = hsel;
        i_htrans      = htrans;
        i_hreadyout_s = rdy;
        i_hresp_s     = resp;
        i_hrdata_s    = {d1, d0};
        @(negedge i_hclk);
        case (m_kind)
            1: begin
                e_rdy  = rdy[m_idx];
                e_resp = resp[m_idx];
                e_data = (m_idx == 0) ? d0 : d1;
            end
            2: begin e_rdy = 1'b0; e_resp = 1'b1; e_data = 32'h0; end
            3: begin e_rdy = 1'b1; e_resp = 1'b1; e_data = 32'h0; end
            default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0; end
        endcase
        obs_rdy  = o_hready;
        obs_resp = o_hresp;
        obs_data = o_hrdata;
        check_val("model_hready", {31'h0, o_hready}, {31'h0, e_rdy});
        check_val("model_hresp",  {31'h0, o_hresp},  {31'h0, e_resp});
        check_val("model_hrdata", o_hrdata, e_data);
        @(posedge i_hclk);
        if (e_rdy) begin
            if (hsel != 2'b00) begin
                m_kind = 1;
                m_idx  = hsel[0] ? 0 : 1;
            end else if (htrans >= 2'd2) begin
                m_kind = 2;
            end else begin
                m_kind = 0;
            end
        end else if (m_kind == 2) begin
            m_kind = 3;
        end
        #1;
    endtask

    logic        r_o, s_o;
    logic [31:0] d_o;

    initial begin
        // Reset with slaves driving stall and junk data
        i_hresetn     = 1'b0;
        i_hsel        = 2'b00;
        i_htrans      = 2'b00;
        i_hreadyout_s = 2'b00;
        i_hresp_s     = 2'b00;
        i_hrdata_s    = {32'hDEADBEEF, 32'hDEADBEEF};
        repeat (3) @(posedge i_hclk);
        @(negedge i_hclk);
        check_val("rst_hready", {31'h0, o_hready}, 32'h1);
        check_val("rst_hresp",  {31'h0, o_hresp},  32'h0);
        check_val("rst_hrdata", o_hrdata, 32'h0);
        @(posedge i_hclk); #1;
        i_hresetn = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, r_o, s_o, d_o);
        check_val("post_rst_hready", {31'h0, r_o}, 32'h1);

        // Read from slave1 with two wait states
        cyc(2'b10, 2'b10, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h11110000, 32'h0, r_o, s_o, d_o);
        check_val("s1_wait1", {31'h0, r_o}, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h11110000, 32'h0, r_o, s_o, d_o);
        check_val("s1_wait2", {31'h0, r_o}, 32'h0);
        cyc(2'b00, 2'b00, 2'b10, 2'b00, 32'h11110000, 32'hA5A50001, r_o, s_o, d_o);
        check_val("s1_ready", {31'h0, r_o}, 32'h1);
        check_val("s1_data", d_o, 32'hA5A50001);

        // Unmapped NONSEQ -> two-cycle ERROR; unmapped IDLE -> OKAY
        cyc(2'b00, 2'b10, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        check_val("err1", {30'h0, r_o, s_o}, 32'h1);
        cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        check_val("err2", {30'h0, r_o, s_o}, 32'h3);
        cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        check_val("after_err", {30'h0, r_o, s_o}, 32'h2);

        // Pipelined slave0 -> slave1; address change during the wait is ignored
        cyc(2'b01, 2'b10, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        cyc(2'b00, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        check_val("pipe_wait", {31'h0, r_o}, 32'h0);
        cyc(2'b10, 2'b11, 2'b11, 2'b00, 32'h000000A0, 32'h0, r_o, s_o, d_o);
        check_val("pipe_beat0", d_o, 32'h000000A0);
        cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h000000B1, r_o, s_o, d_o);
        check_val("pipe_beat1", {d_o[29:0], r_o, s_o}, {30'h000000B1 & 30'h3FFFFFFF, 2'b10});
        cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        check_val("pipe_end", {30'h0, r_o, s_o}, 32'h2);

        // Overlapping select: lowest index wins
        cyc(2'b11, 2'b10, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        cyc(2'b00, 2'b00, 2'b01, 2'b10, 32'h000000C0, 32'h000000C1, r_o, s_o, d_o);
        check_val("overlap_data", d_o, 32'h000000C0);
        check_val("overlap_rs", {30'h0, r_o, s_o}, 32'h2);

        // Reset asserted while in the first ERROR cycle
        cyc(2'b00, 2'b10, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
        #2;
        check_val("err1_before_rst", {31'h0, o_hready}, 32'h0);
        i_hresetn = 1'b0;
        #1;
        check_val("midrst_hready", {31'h0, o_hready}, 32'h1);
        check_val("midrst_hresp",  {31'h0, o_hresp},  32'h0);
        m_kind = 0;
        @(posedge i_hclk); #1;
        i_hresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0, r_o, s_o, d_o);
            check_val("no_err_after_rst", {30'h0, r_o, s_o}, 32'h2);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [1:0] rdy;
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 3) != 0);
            cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rdy,
                2'($urandom_range(0, 3)), $urandom, $urandom, r_o, s_o, d_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
